lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
- Load/store unit between the RISC-V core datapath and the data RAM.
- Adds handshaked requests, RV32I sub-word access (LB/LH/LW/LBU/LHU/SB/SH/SW), byte-enable stores, a parametrised RAM read latency and misalignment detection.
- Successor to the fixed-width, zero-wait-state RAM port: the core issues byte addresses, and the block drives word-addressed RAM with per-byte write enables.

Parameters:
- SIZE, 32, data width in bits; only 32 is supported (elaboration error otherwise).
- ADDR_WIDTH, 10, RAM word-address width; the core byte address is ADDR_WIDTH+2 bits.
- RD_LATENCY, 1, cycles from RAM address to valid Q_RAM; legal range 1..7.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  SIZE  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  SIZE  load result, extended per funct3.
- rsp_err  out  1  misaligned or illegal-funct3 access.
- ADDR_RAM  out  ADDR_WIDTH  RAM word address, req_addr[ADDR_WIDTH+1:2].
- Q_W  out  SIZE  RAM write data, lane-shifted.
- ENABLE_W  out  1  RAM write strobe.
- BE_W  out  SIZE/8  RAM byte enables.
- Q_RAM  in  SIZE  RAM read data.

Behaviour:
- Reset values (applied immediately on rst): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ADDR_RAM=0, Q_W=0, ENABLE_W=0, BE_W=0, latency counter 0.
- Reset asserted mid-operation aborts the operation; any ENABLE_W in progress drops asynchronously; no response is produced.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- req_ready=1 only in IDLE. A request is accepted on a cycle T with req_valid&&req_ready; req_* are latched at that edge.
- Error check at acceptance:
  - funct3 is not in {000,001,010,100,101}, or H/HU has addr[0]!=0, or W has addr[1:0]!=0.
  - On error: go to RESP, no RAM access. Cycle T+1: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Store, cycle T+1 (ACCESS):
  - ENABLE_W=1; ADDR_RAM=word address.
  - Q_W = wdata replicated/shifted into lane addr[1:0].
  - BE_W: B = 1<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
  - Cycle T+2 (RESP): rsp_valid=1, rsp_err=0. ENABLE_W is high for exactly one cycle.
- Load, cycle T+1 (ACCESS):
  - ADDR_RAM driven, ENABLE_W=0, BE_W=0.
  - WAIT counts RD_LATENCY cycles.
  - Q_RAM is sampled at the end of cycle T+1+RD_LATENCY.
  - rsp_valid in cycle T+2+RD_LATENCY.
  - Lane select by addr[1:0]; B/H sign-extended, BU/HU zero-extended, W passed through.
- Response: rsp_valid is a single-cycle pulse with no backpressure. RESP always returns to IDLE, so the next request is acceptable at the cycle after RESP.
- Between operations, ADDR_RAM/Q_W hold their last values; ENABLE_W and BE_W are 0.
- Top byte address wraps naturally; there is no range check.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- When defined, adds three outputs (each 32 bits, clear on rst, wrap at 2^32):
  - perf_loads: +1 per successful load response.
  - perf_stores: +1 per successful store response.
  - perf_errs: +1 per rsp_err response.
- Counts are visible in the cycle after the response.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- SW addr 0x008 wdata 0xDEADBEEF -> cycle T+1: ENABLE_W=1, ADDR_RAM=2, BE_W=1111, Q_W=0xDEADBEEF; rsp_valid at T+2, rsp_err=0.
- SB addr 0x00B wdata 0x000000A5 -> BE_W=1000, Q_W[31:24]=0xA5; then LBU 0x00B returns 0x000000A5 and LB 0x00B returns 0xFFFFFFA5.
- LH 0x006 with Q_RAM=0x8001_1234, RD_LATENCY=3 -> rsp_valid exactly T+5, rsp_rdata=0xFFFF8001; LHU gives 0x00008001.
- LW 0x005 -> rsp_valid at T+1, rsp_err=1, rsp_rdata=0, no ENABLE_W, ADDR_RAM unchanged; funct3=011 also gives rsp_err=1.
- rst pulsed during WAIT of a load -> outputs at reset values immediately, no rsp_valid, req_ready=1 after release; back-to-back requests with req_valid held high are accepted only in IDLE.
- With LSU_PERF_CNT_EN: 2 loads, 1 store, 1 misaligned -> perf_loads=2, perf_stores=1, perf_errs=1.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit: byte-addressed handshaked core requests to a word-addressed RAM.
// Optional performance counters are enabled by defining LSU_PERF_CNT_EN.
module lsu_mem_port #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [SIZE-1:0]       req_wdata,
    output logic                  rsp_valid,
    output logic [SIZE-1:0]       rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ADDR_RAM,
    output logic [SIZE-1:0]       Q_W,
    output logic                  ENABLE_W,
    output logic [SIZE/8-1:0]     BE_W,
    input  logic [SIZE-1:0]       Q_RAM
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]           perf_loads,
    output logic [31:0]           perf_stores,
    output logic [31:0]           perf_errs
`endif
);

    generate
        if (SIZE != 32) begin : g_size_chk
            $error("lsu_mem_port: only SIZE=32 is supported");
        end
        if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_lat_chk
            $error("lsu_mem_port: RD_LATENCY must be within 1..7");
        end
    endgenerate

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_ram_q, addr_ram_d;
    logic [SIZE-1:0]       q_w_q, q_w_d;
    logic                  en_w_q, en_w_d;
    logic [SIZE/8-1:0]     be_w_q, be_w_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [SIZE-1:0]       rsp_rdata_q, rsp_rdata_d;

    logic                  req_err;
    logic [SIZE/8-1:0]     be_new;
    logic [SIZE-1:0]       qw_new;
    logic [SIZE-1:0]       rd_shift;
    logic [SIZE-1:0]       load_data;

    // Illegal funct3 or an access that crosses its natural alignment.
    always_comb begin
        case (req_funct3)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = req_addr[0];
            3'b010:         req_err = |req_addr[1:0];
            default:        req_err = 1'b1;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                be_new = 4'b0001 << req_addr[1:0];
                qw_new = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_new = 4'b0011 << req_addr[1:0];
                qw_new = {2{req_wdata[15:0]}};
            end
            default: begin
                be_new = 4'b1111;
                qw_new = req_wdata;
            end
        endcase
    end

    assign rd_shift = Q_RAM >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_data = {24'd0, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_data = {16'd0, rd_shift[15:0]};
            default: load_data = Q_RAM;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        addr_ram_d  = addr_ram_q;
        q_w_d       = q_w_q;
        en_w_d      = 1'b0;
        be_w_d      = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d  = req_we;
                    f3_d  = req_funct3;
                    off_d = req_addr[1:0];
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d    = ACCESS;
                        addr_ram_d = req_addr[ADDR_WIDTH+1:2];
                        if (req_we) begin
                            en_w_d = 1'b1;
                            be_w_d = be_new;
                            q_w_d  = qw_new;
                        end
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 3'(RD_LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_data;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            cnt_q       <= 3'd0;
            addr_ram_q  <= '0;
            q_w_q       <= '0;
            en_w_q      <= 1'b0;
            be_w_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            addr_ram_q  <= addr_ram_d;
            q_w_q       <= q_w_d;
            en_w_q      <= en_w_d;
            be_w_q      <= be_w_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ADDR_RAM  = addr_ram_q;
    assign Q_W       = q_w_q;
    assign ENABLE_W  = en_w_q;
    assign BE_W      = be_w_q;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads_q, perf_stores_q, perf_errs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loads_q  <= 32'd0;
            perf_stores_q <= 32'd0;
            perf_errs_q   <= 32'd0;
        end else if (rsp_valid_q) begin
            if (rsp_err_q)   perf_errs_q   <= perf_errs_q + 32'd1;
            else if (we_q)   perf_stores_q <= perf_stores_q + 32'd1;
            else             perf_loads_q  <= perf_loads_q + 32'd1;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
    assign perf_errs   = perf_errs_q;
`endif

endmodule
